button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 The module SHALL have parameter clk_freq, default 50_000_000, system clock frequency in Hz.
REQ-002 The module SHALL have parameter repeat_delay_ms, default 500, hold time before the first auto-repeat.
REQ-003 The module SHALL have parameter repeat_period_ms, default 100, interval between subsequent auto-repeats.
REQ-004 The module SHALL have parameter long_press_ms, default 1000, hold time at which a press counts as long.
REQ-005 The module SHALL have parameter pressed_level, default 0, the level value that means "pressed" (0 for active-low keys).
REQ-006 The module SHALL have port clk, input, 1 bit, the single system clock.
REQ-007 The module SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 The module SHALL have port level, input, 1 bit, debounced button level, already synchronous to clk.
REQ-009 The module SHALL have port press_pulse, output, 1 bit, one-cycle pulse on each press.
REQ-010 The module SHALL have port release_pulse, output, 1 bit, one-cycle pulse on each release.
REQ-011 The module SHALL have port repeat_pulse, output, 1 bit, one-cycle pulse on each auto-repeat.
REQ-012 The module SHALL have port step_pulse, output, 1 bit, equal to press_pulse OR repeat_pulse.
REQ-013 The module SHALL have port held, output, 1 bit, high while the button is pressed.
REQ-014 The module SHALL have port long_press, output, 1 bit, high from the long-press threshold until release.

Function
REQ-015 The module SHALL derive cycle counts as X_CYC = clk_freq/1000*X_ms for delay, period and long press, with widths of $clog2(X_CYC)+1 bits; elaboration SHALL fail unless DELAY_CYC>=2, PERIOD_CYC>=1 and LONG_CYC>=1.
REQ-016 The module SHALL implement the FSM states RELEASED, HELD_DELAY and HELD_REPEAT, with every output registered.
REQ-017 In RELEASED, on a clock edge where level==pressed_level, the module SHALL go to HELD_DELAY, clear the repeat and long counters, and assert press_pulse and held; press_pulse SHALL be visible in the cycle following that edge, so latency is 1 cycle.
REQ-018 In HELD_DELAY, the repeat counter SHALL increment each edge; on the edge where it equals DELAY_CYC-1, the module SHALL assert repeat_pulse, clear the counter and enter HELD_REPEAT. The first repeat SHALL therefore come DELAY_CYC edges after the press edge.
REQ-019 In HELD_REPEAT, on the edge where the counter equals PERIOD_CYC-1, the module SHALL assert repeat_pulse and clear the counter. Repeats SHALL therefore occur every PERIOD_CYC edges, indefinitely.
REQ-020 The long counter SHALL increment in both held states and saturate at LONG_CYC-1; long_press SHALL rise on the edge where the counter reaches LONG_CYC-1 and stay high while the button is held.
REQ-021 In either held state, on an edge where level!=pressed_level, the module SHALL assert release_pulse, deassert held and long_press, clear both counters and return to RELEASED.
REQ-022 Release SHALL take priority: no repeat_pulse is issued on the release edge, even if the counter hits its terminal value.
REQ-023 press_pulse, repeat_pulse and release_pulse SHALL each be high for exactly one cycle per event and SHALL never be high together.
REQ-024 A press lasting a single cycle SHALL produce press_pulse followed by release_pulse on the next cycle, with no repeat or long_press.
REQ-025 The counters SHALL never wrap around.

Reset
REQ-026 While reset is high, the module SHALL be in RELEASED with both counters at 0 and all outputs at 0, independent of clk.
REQ-027 A reset asserted while the button is held SHALL abort the press with no release_pulse.
REQ-028 After reset deasserts with level already pressed, the first edge SHALL produce press_pulse.

Verification (clk_freq=1000, delay=5, period=3, long=10, pressed_level=0)
REQ-029 Reset with level=1 -> all outputs 0; level->0 before edge k -> press_pulse and step_pulse high in cycle k+1 only, held=1.
REQ-030 Hold level=0 for 20 edges -> repeat_pulse at edges k+5, k+8, k+11, k+14, k+17; long_press rises at edge k+10.
REQ-031 Release at edge k+8, coinciding with the first period terminal -> release_pulse only, no repeat_pulse; held=0 and long_press=0.
REQ-032 level=0 for one cycle -> press_pulse then release_pulse on consecutive cycles, with no repeat.
REQ-033 Reset asserted mid-hold at k+7 -> outputs 0 asynchronously, no release_pulse; level still 0 after deassert -> new press_pulse on the next edge.
REQ-034 Across randomized level toggling, the bench SHALL check that the one-cycle pulses are mutually exclusive and that step_pulse==press_pulse|repeat_pulse at all times.

Source files
------------

// File: rtl/button_event.sv
// Button event generator: turns a clean, clk-synchronous button level into
// press / release / auto-repeat pulses plus held and long-press status.
module button_event #(
  parameter int unsigned clk_freq         = 50_000_000,
  parameter int unsigned repeat_delay_ms  = 500,
  parameter int unsigned repeat_period_ms = 100,
  parameter int unsigned long_press_ms    = 1000,
  parameter bit          pressed_level    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic held,
  output logic long_press
);

  // Timing expressed in clock cycles
  localparam int unsigned DELAY_CYC  = clk_freq / 1000 * repeat_delay_ms;
  localparam int unsigned PERIOD_CYC = clk_freq / 1000 * repeat_period_ms;
  localparam int unsigned LONG_CYC   = clk_freq / 1000 * long_press_ms;

  localparam int unsigned DW = $clog2(DELAY_CYC) + 1;
  localparam int unsigned PW = $clog2(PERIOD_CYC) + 1;
  localparam int unsigned LW = $clog2(LONG_CYC) + 1;
  // One repeat counter serves both the initial delay and the period
  localparam int unsigned RW = (DW > PW) ? DW : PW;

  localparam logic [RW-1:0] DELAY_LAST  = RW'(DELAY_CYC - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(PERIOD_CYC - 1);
  localparam logic [LW-1:0] LONG_LAST   = LW'(LONG_CYC - 1);

  // Reject timing parameters the counters cannot represent
  if (DELAY_CYC < 2) begin : g_bad_delay
    $error("button_event: repeat delay must be at least 2 clock cycles");
  end
  if (PERIOD_CYC < 1) begin : g_bad_period
    $error("button_event: repeat period must be at least 1 clock cycle");
  end
  if (LONG_CYC < 1) begin : g_bad_long
    $error("button_event: long-press time must be at least 1 clock cycle");
  end

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          step_q, step_d;
  logic          held_q, held_d;
  logic          long_press_q, long_press_d;

  logic          pressed;

  assign pressed = (level == pressed_level);

  // Next-state, counter and output decode
  always_comb begin
    state_d      = state_q;
    rep_cnt_d    = rep_cnt_q;
    long_cnt_d   = long_cnt_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    repeat_d     = 1'b0;
    held_d       = held_q;
    long_press_d = long_press_q;

    case (state_q)
      RELEASED: begin
        held_d       = 1'b0;
        long_press_d = 1'b0;
        if (pressed) begin
          state_d    = HELD_DELAY;
          rep_cnt_d  = '0;
          long_cnt_d = '0;
          press_d    = 1'b1;
          held_d     = 1'b1;
        end
      end

      HELD_DELAY, HELD_REPEAT: begin
        if (!pressed) begin
          // Release wins over any repeat terminal count on the same edge
          state_d      = RELEASED;
          rep_cnt_d    = '0;
          long_cnt_d   = '0;
          release_d    = 1'b1;
          held_d       = 1'b0;
          long_press_d = 1'b0;
        end else begin
          held_d = 1'b1;

          // Long-press counter saturates at its terminal value
          if (long_cnt_q == LONG_LAST) begin
            long_press_d = 1'b1;
          end else begin
            long_cnt_d = LW'(long_cnt_q + 1'b1);
          end

          if (state_q == HELD_DELAY) begin
            if (rep_cnt_q == DELAY_LAST) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
              state_d   = HELD_REPEAT;
            end else begin
              rep_cnt_d = RW'(rep_cnt_q + 1'b1);
            end
          end else begin
            if (rep_cnt_q == PERIOD_LAST) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = RW'(rep_cnt_q + 1'b1);
            end
          end
        end
      end

      default: begin
        state_d      = RELEASED;
        rep_cnt_d    = '0;
        long_cnt_d   = '0;
        held_d       = 1'b0;
        long_press_d = 1'b0;
      end
    endcase

    step_d = press_d | repeat_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RELEASED;
      rep_cnt_q    <= '0;
      long_cnt_q   <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      repeat_q     <= 1'b0;
      step_q       <= 1'b0;
      held_q       <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rep_cnt_q    <= rep_cnt_d;
      long_cnt_q   <= long_cnt_d;
      press_q      <= press_d;
      release_q    <= release_d;
      repeat_q     <= repeat_d;
      step_q       <= step_d;
      held_q       <= held_d;
      long_press_q <= long_press_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = step_q;
  assign held          = held_q;
  assign long_press    = long_press_q;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios plus randomized
// level toggling, compared every cycle against a hold-age based model.
module tb_button_event;

  localparam int unsigned D = 5;   // delay cycles
  localparam int unsigned P = 3;   // period cycles
  localparam int unsigned L = 10;  // long-press cycles

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic level = 1'b1;
  logic press_pulse, release_pulse, repeat_pulse, step_pulse, held, long_press;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: whether the button is held and edges elapsed since the press
  bit m_held = 1'b0;
  int m_age  = 0;
  logic e_press = 1'b0, e_rel = 1'b0, e_rep = 1'b0, e_held = 1'b0, e_long = 1'b0;

  button_event #(
    .clk_freq(1000),
    .repeat_delay_ms(D),
    .repeat_period_ms(P),
    .long_press_ms(L),
    .pressed_level(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .step_pulse(step_pulse),
    .held(held),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: outputs follow from the hold age alone
  always @(posedge clk or posedge reset) begin : model
    bit h;
    int a;
    logic p, r, rp;
    if (reset) begin
      m_held  <= 1'b0;
      m_age   <= 0;
      e_press <= 1'b0;
      e_rel   <= 1'b0;
      e_rep   <= 1'b0;
      e_held  <= 1'b0;
      e_long  <= 1'b0;
    end else begin
      h = m_held;
      a = m_age;
      p = 1'b0;
      r = 1'b0;
      rp = 1'b0;
      if (!h) begin
        if (level == 1'b0) begin
          h = 1'b1;
          a = 0;
          p = 1'b1;
        end
      end else if (level != 1'b0) begin
        h = 1'b0;
        r = 1'b1;
      end else begin
        a = a + 1;
        rp = (a >= int'(D)) && (((a - int'(D)) % int'(P)) == 0);
      end
      m_held  <= h;
      m_age   <= a;
      e_press <= p;
      e_rel   <= r;
      e_rep   <= rp;
      e_held  <= h;
      e_long  <= h && (a >= int'(L));
    end
  end

  // Per-cycle comparison against the model plus pulse invariants
  always @(negedge clk) begin
    if (chk_en) begin
      chk("press", press_pulse, e_press);
      chk("release", release_pulse, e_rel);
      chk("repeat", repeat_pulse, e_rep);
      chk("held", held, e_held);
      chk("long", long_press, e_long);
      chk("step_eq", step_pulse, press_pulse | repeat_pulse);
      chk("pulse_excl", $onehot0({press_pulse, release_pulse, repeat_pulse}), 1'b1);
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_press"}, press_pulse, 1'b0);
    chk({name, "_release"}, release_pulse, 1'b0);
    chk({name, "_repeat"}, repeat_pulse, 1'b0);
    chk({name, "_step"}, step_pulse, 1'b0);
    chk({name, "_held"}, held, 1'b0);
    chk({name, "_long"}, long_press, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      level = 1'b1;
    end
  endtask

  initial begin
    // Reset state, observed without any clock edge in between
    #1 reset = 1'b1;
    #1 chk_all_zero("rst");
    repeat (3) @(negedge clk);
    chk_all_zero("rst_clk");
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Long hold: press, repeats at +5,+8,+11,+14,+17, long at +10, release at +20
    level = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("lit_press", press_pulse, n == 0);
      chk("lit_step", step_pulse, (n == 0) || (n inside {5, 8, 11, 14, 17}));
      chk("lit_rep", repeat_pulse, n inside {5, 8, 11, 14, 17});
      chk("lit_model_rep", e_rep, n inside {5, 8, 11, 14, 17});
      chk("lit_long", long_press, n >= 10);
      chk("lit_model_long", e_long, n >= 10);
      chk("lit_held", held, 1'b1);
      if (n == 19) level = 1'b1;
    end
    @(negedge clk);
    chk("lit_rel20", release_pulse, 1'b1);
    chk("lit_norep20", repeat_pulse, 1'b0);
    chk("lit_model_norep20", e_rep, 1'b0);
    chk("lit_held20", held, 1'b0);
    idle(3);

    // Release on the first period terminal edge
    level = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n == 7) level = 1'b1;
    end
    chk("lit_rel8", release_pulse, 1'b1);
    chk("lit_norep8", repeat_pulse, 1'b0);
    chk("lit_held8", held, 1'b0);
    chk("lit_long8", long_press, 1'b0);
    idle(3);

    // Single-cycle press
    level = 1'b0;
    @(negedge clk);
    chk("lit_1c_press", press_pulse, 1'b1);
    level = 1'b1;
    @(negedge clk);
    chk("lit_1c_rel", release_pulse, 1'b1);
    chk("lit_1c_press_gone", press_pulse, 1'b0);
    chk("lit_1c_norep", repeat_pulse, 1'b0);
    idle(8);
    chk("lit_1c_idle_rep", repeat_pulse, 1'b0);

    // Reset mid-hold at +7, press resumes after deassert
    level = 1'b0;
    for (int n = 0; n <= 7; n++) @(negedge clk);
    chk("lit_mid_held", held, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    chk("mid_rst_norel", release_pulse, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("lit_repress", press_pulse, 1'b1);
    chk("lit_repress_held", held, 1'b1);
    chk("lit_repress_norel", release_pulse, 1'b0);
    idle(3);

    // Randomized toggling with occasional asynchronous resets
    for (int it = 0; it < 150; it++) begin
      int run;
      run = int'($urandom_range(1, 25));
      level = ~level;
      for (int c = 0; c < run; c++) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        #(1 + $urandom_range(0, 2)) reset = 1'b1;
        #1 chk_all_zero("rnd_rst");
        @(negedge clk);
        reset = 1'b0;
      end
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
